// File: rtl/pll_mdrp_if.sv
// pll_mdrp_if: request/response bus between a host and pll_mdrp_ctrl
interface pll_mdrp_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  modport master(output req_valid, req_op, req_addr, req_wdata, input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave(input req_valid, req_op, req_addr, req_wdata, output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/pll_mdrp_ctrl.sv
// pll_mdrp_ctrl: MDRP register access and PLL reset/lock sequencer.
// Define PLL_MDRP_VERIFY_EN to add an automatic readback check after every write.
module pll_mdrp_ctrl #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  pll_mdrp_if.slave   bus,
  output logic [1:0]  mdopc,
  output logic        mdainc,
  output logic [7:0]  mdwdi,
  input  logic [7:0]  mdrdo,
  output logic        pll_reset,
  input  logic        pll_lock
);
`ifdef PLL_MDRP_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam logic [1:0] OP_WR = 2'b00, OP_RD = 2'b01, OP_AP = 2'b10;
  typedef enum logic [2:0] {IDLE, ADDR, WR, RD, RDWAIT, RST, LOCKWAIT, DONE} state_t;
  state_t state, nxt;
  logic [1:0]  op_q;
  logic [7:0]  addr_q, wdata_q, rdata_q;
  logic        err_q, lock_m, lock_s, accept;
  logic [15:0] cnt;
  assign accept = state == IDLE && bus.req_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = !accept ? IDLE : bus.req_op == OP_AP ? RST : bus.req_op == 2'b11 ? DONE : ADDR;
      ADDR:     nxt = op_q == OP_RD ? RD : WR;
      WR:       nxt = VERIFY ? RD : DONE;
      RD:       nxt = RDWAIT;
      RDWAIT:   nxt = cnt == 16'd1 ? DONE : RDWAIT;
      RST:      nxt = cnt == 16'(RST_CYCLES - 1) ? LOCKWAIT : RST;
      LOCKWAIT: nxt = lock_s || cnt == 16'(LOCK_TIMEOUT - 1) ? DONE : LOCKWAIT;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.req_ready = state == IDLE;
    bus.rsp_valid = state == DONE;
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
    mdopc  = state == ADDR ? 2'b11 : state == WR ? 2'b01 : state == RD ? 2'b10 : 2'b00;
    mdwdi  = state == ADDR ? addr_q : state == WR ? wdata_q : 8'h00;
    mdainc = 1'b0;
  end
  // cnt restarts on every state change and saturates, serving RST, RDWAIT and LOCKWAIT
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q      <= 2'b00;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      err_q     <= 1'b0;
      cnt       <= 16'd0;
      pll_reset <= 1'b1;
      lock_m    <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      {lock_s, lock_m} <= {lock_m, pll_lock};
      cnt       <= nxt != state ? 16'd0 : cnt + 16'(cnt != 16'hFFFF);
      pll_reset <= nxt == RST;
      if (accept) begin
        op_q    <= bus.req_op;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (accept && bus.req_op == 2'b11) begin
        rdata_q <= 8'h00;
        err_q   <= 1'b1;
      end
      if (state == WR) err_q <= 1'b0;
      if (state == RDWAIT && cnt == 16'd1) begin
        rdata_q <= mdrdo;
        err_q   <= op_q == OP_WR && mdrdo != wdata_q;
      end
      if (state == LOCKWAIT && nxt == DONE) err_q <= !lock_s;
    end
endmodule

// File: tb/tb_pll_mdrp_ctrl.sv
// tb_pll_mdrp_ctrl: vector table, random ops vs reference model, lock/timeout/reset corners
module tb_pll_mdrp_ctrl;
`ifdef PLL_MDRP_VERIFY_EN
  localparam bit V = 1'b1;
`else
  localparam bit V = 1'b0;
`endif
  localparam int RC = 16, LT = 128;
  logic clk = 0, rst_n = 0, mdainc, pll_reset, pll_lock = 1, corrupt = 0;
  logic [1:0] mdopc;
  logic [7:0] mdwdi, mdrdo, pll_addr;
  logic [7:0] pll_mem[256], ref_mem[256];
  logic [7:0] last_rdata;
  int total = 0, passed = 0;
  pll_mdrp_if bus();
  pll_mdrp_ctrl #(.RST_CYCLES(RC), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .mdopc(mdopc), .mdainc(mdainc),
    .mdwdi(mdwdi), .mdrdo(mdrdo), .pll_reset(pll_reset), .pll_lock(pll_lock));
  always #5 clk = ~clk;
  always @(posedge clk)
    if (mdopc == 2'b11) pll_addr <= mdwdi;
    else if (mdopc == 2'b01) pll_mem[pll_addr] <= mdwdi;
  assign mdrdo = pll_mem[pll_addr] ^ {7'b0, corrupt};
  typedef struct {logic [1:0] op; logic [7:0] addr, wdata; logic err; logic [7:0] rdata;} vec_t;
  vec_t tbl[7];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", n, act, exp);
  endtask
  function automatic int exp_lat(input logic [1:0] op);
    return op == 2'b00 ? (V ? 6 : 3) : op == 2'b01 ? 5 : op == 2'b11 ? 1 : RC + 2;
  endfunction
  task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] w, output int lat,
                       output logic err, output logic [7:0] rd, output logic [9:0] t1, output logic [9:0] t2,
                       output int rst_hi);
    @(negedge clk);
    bus.req_valid = 1; bus.req_op = op; bus.req_addr = a; bus.req_wdata = w;
    @(negedge clk);
    bus.req_valid = 0; bus.req_op = 2'($urandom); bus.req_addr = 8'($urandom); bus.req_wdata = 8'($urandom);
    lat = 1; rst_hi = 0; t1 = 0; t2 = 0;
    while (lat < 1000) begin
      if (lat == 1) t1 = {mdopc, mdwdi};
      if (lat == 2) t2 = {mdopc, mdwdi};
      if (bus.rsp_valid) break;
      rst_hi += int'(pll_reset);
      @(negedge clk);
      lat++;
    end
    err = bus.rsp_err; rd = bus.rsp_rdata;
  endtask
  task automatic apply_lock(input int n, input logic eerr, input int elat, input string nm);
    int lat, rh;
    logic err;
    logic [7:0] rd;
    logic [9:0] t1, t2;
    pll_lock = 0;
    fork
      do_op(2'b10, 8'h00, 8'h00, lat, err, rd, t1, t2, rh);
      begin
        int k = 0;
        @(negedge clk);
        while (!pll_reset && k < 50) begin @(negedge clk); k++; end
        while (pll_reset && k < 100) begin @(negedge clk); k++; end
        if (n >= 0) begin repeat (n) @(negedge clk); pll_lock = 1; end
      end
    join
    chk({nm, "_err"}, 32'(err), 32'(eerr));
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_rsthi"}, rh, RC);
  endtask
  initial begin
    int lat, rh, seen;
    logic err;
    logic [7:0] rd, exp_rd;
    logic [9:0] t1, t2;
    for (int i = 0; i < 256; i++) begin pll_mem[i] = 8'(i) ^ 8'hA0; ref_mem[i] = 8'(i) ^ 8'hA0; end
    bus.req_valid = 0; bus.req_op = 0; bus.req_addr = 0; bus.req_wdata = 0;
    last_rdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_err", 32'(bus.rsp_err), 0);
    chk("rst_rdata", 32'(bus.rsp_rdata), 0);
    chk("rst_mdopc_mdwdi", {mdopc, mdwdi}, 0);
    chk("rst_mdainc", 32'(mdainc), 0);
    chk("rst_pll_reset", 32'(pll_reset), 1);
    #2 rst_n = 1;
    @(negedge clk);
    chk("rel_pll_reset", 32'(pll_reset), 0);
    tbl[0] = '{2'b01, 8'h05, 8'h00, 1'b0, 8'hA5};
    tbl[1] = '{2'b00, 8'h12, 8'h14, 1'b0, V ? 8'h14 : 8'hA5};
    tbl[2] = '{2'b01, 8'h12, 8'h00, 1'b0, 8'h14};
    tbl[3] = '{2'b11, 8'h77, 8'h55, 1'b1, 8'h00};
    tbl[4] = '{2'b00, 8'h33, 8'h5A, 1'b0, V ? 8'h5A : 8'h00};
    tbl[5] = '{2'b01, 8'h33, 8'h00, 1'b0, 8'h5A};
    tbl[6] = '{2'b01, 8'h34, 8'h00, 1'b0, 8'h94};
    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i].op, tbl[i].addr, tbl[i].wdata, lat, err, rd, t1, t2, rh);
      chk($sformatf("vec%0d_lat", i), lat, exp_lat(tbl[i].op));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].err));
      chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(tbl[i].rdata));
      if (tbl[i].op != 2'b11) begin
        chk($sformatf("vec%0d_md1", i), 32'(t1), {22'd0, 2'b11, tbl[i].addr});
        chk($sformatf("vec%0d_md2", i), 32'(t2), tbl[i].op == 2'b00 ? {22'd0, 2'b01, tbl[i].wdata} : {22'd0, 2'b10, 8'h00});
      end
      if (tbl[i].op == 2'b00) ref_mem[tbl[i].addr] = tbl[i].wdata;
    end
    last_rdata = 8'h94;
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op = 2'($urandom_range(0, 3));
      logic [7:0] a = 8'($urandom), w = 8'($urandom);
      do_op(op, a, w, lat, err, rd, t1, t2, rh);
      if (op == 2'b00) begin ref_mem[a] = w; if (V) last_rdata = w; end
      else if (op == 2'b01) last_rdata = ref_mem[a];
      else if (op == 2'b11) last_rdata = 8'h00;
      exp_rd = last_rdata;
      chk($sformatf("rnd%0d_op%0d_lat", i, op), lat, exp_lat(op));
      chk($sformatf("rnd%0d_op%0d_err", i, op), 32'(err), 32'(op == 2'b11));
      chk($sformatf("rnd%0d_op%0d_rdata", i, op), 32'(rd), 32'(exp_rd));
    end
    apply_lock(100, 1'b0, 120, "apply_lock100");
    apply_lock(LT - 3, 1'b0, 1 + RC + LT, "apply_lock_lastcycle");
    apply_lock(LT - 2, 1'b1, 1 + RC + LT, "apply_lock_late");
    apply_lock(-1, 1'b1, 1 + RC + LT, "apply_timeout");
    @(negedge clk);
    chk("timeout_ready", 32'(bus.req_ready), 1);
    pll_lock = 1;
    do_op(2'b11, 8'h01, 8'h02, lat, err, rd, t1, t2, rh);
    chk("reserved_err", 32'(err), 1);
    chk("reserved_rdata", 32'(rd), 0);
`ifdef PLL_MDRP_VERIFY_EN
    corrupt = 1;
    do_op(2'b00, 8'h40, 8'h77, lat, err, rd, t1, t2, rh);
    corrupt = 0;
    chk("verify_corrupt_err", 32'(err), 1);
    chk("verify_corrupt_rdata", 32'(rd), 32'h76);
`endif
    pll_lock = 0;
    @(negedge clk);
    bus.req_valid = 1; bus.req_op = 2'b10;
    @(negedge clk);
    bus.req_valid = 0;
    seen = 0;
    repeat (30) @(negedge clk) seen += int'(bus.rsp_valid);
    #2 rst_n = 0;
    #1;
    chk("midrst_pll_reset", 32'(pll_reset), 1);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
    repeat (3) @(negedge clk) seen += int'(bus.rsp_valid);
    #2 rst_n = 1;
    repeat (200) @(negedge clk) seen += int'(bus.rsp_valid);
    chk("midrst_no_rsp", seen, 0);
    chk("midrst_ready", 32'(bus.req_ready), 1);
    chk("midrst_pll_reset_low", 32'(pll_reset), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pll_mdrp_ctrl.md
PLL_MDRP_CTRL -- requirements
Module: pll_mdrp_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: PLL reset pulse width in clk cycles.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: maximum clk cycles to wait for lock after reset.
REQ-003 SHALL have port clk  input  1: single clock; the PLL mdclk pin is tied to this same clock at top level.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1: request strobe.
REQ-006 SHALL have port req_ready  output  1: controller idle, request accepted when req_valid and req_ready are both high.
REQ-007 SHALL have port req_op  input  2: request opcode; 00 write, 01 read, 10 apply, 11 reserved.
REQ-008 SHALL have port req_addr  input  8: MDRP register address.
REQ-009 SHALL have port req_wdata  input  8: MDRP write data.
REQ-010 SHALL have port rsp_valid  output  1: one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  output  8: read data, valid with rsp_valid.
REQ-012 SHALL have port rsp_err  output  1: error flag, valid with rsp_valid.
REQ-013 SHALL have port mdopc  output  2: PLL MDRP opcode; 00 nop, 01 write, 10 read, 11 load address.
REQ-014 SHALL have port mdainc  output  1: address auto-increment, always driven 0.
REQ-015 SHALL have port mdwdi  output  8: PLL MDRP write data or address.
REQ-016 SHALL have port mdrdo  input  8: PLL MDRP read data.
REQ-017 SHALL have port pll_reset  output  1: PLL reset, active-high.
REQ-018 SHALL have port pll_lock  input  1: PLL lock; asynchronous, two-flop synchronised internally.

Function
REQ-019 SHALL use states IDLE, ADDR, WR, RD, RDWAIT, RST, LOCKWAIT, DONE; req_ready is high only in IDLE.
REQ-020 SHALL latch op, addr and wdata on acceptance and ignore all req_* inputs outside IDLE.
REQ-021 On write: ADDR (mdopc=11, mdwdi=addr) for 1 cycle, then WR (mdopc=01, mdwdi=wdata) for 1 cycle, then DONE; rsp_valid occurs 3 cycles after acceptance.
REQ-022 On read: ADDR for 1 cycle, RD (mdopc=10) for 1 cycle, then RDWAIT for 2 cycles; mdrdo is captured on the last RDWAIT cycle, then DONE.
REQ-023 SHALL drive mdopc=00 and mdwdi=00 in every state other than ADDR and WR.
REQ-024 On apply: RST asserts pll_reset for exactly RST_CYCLES cycles, then LOCKWAIT runs until the synchronised lock is high or LOCK_TIMEOUT cycles elapse.
REQ-025 Apply response: rsp_err=0 if lock is seen; rsp_err=1 on timeout; lock seen on the timeout cycle counts as success.
REQ-026 Reserved op 11 SHALL go directly to DONE with rsp_err=1 and rsp_rdata=00.
REQ-027 DONE SHALL assert rsp_valid for 1 cycle and return to IDLE; rsp_rdata holds its value until the next read completes.
REQ-028 The timeout counter SHALL be 16 bits, saturating, and cleared on entry to LOCKWAIT.

Reset
REQ-029 While rst_n is low, outputs SHALL be: state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=00, mdopc=00, mdwdi=00, mdainc=0, pll_reset=1.
REQ-030 On rst_n release, pll_reset SHALL deassert on the first clk edge; reset asserted mid-operation SHALL abort the operation without issuing a response.

Configuration
REQ-031 With PLL_MDRP_VERIFY_EN defined, every write SHALL be followed by an automatic readback (RD, RDWAIT) of the same address; rsp_err=1 if the readback differs from wdata, and rsp_rdata carries the readback value; write latency becomes 6 cycles.
REQ-032 With PLL_MDRP_VERIFY_EN undefined, a write SHALL complete per REQ-021 with rsp_err=0 and rsp_rdata unchanged.

Verification
REQ-033 Write addr=0x12, wdata=0x14 -> mdopc 11/0x12 then 01/0x14 on consecutive cycles; rsp_valid 3 cycles after acceptance, err=0 (6 cycles with VERIFY, PLL model echoing data).
REQ-034 Read addr=0x05, model returns mdrdo=0xA5 -> rsp_rdata=0xA5, err=0, rsp_valid 5 cycles after acceptance.
REQ-035 Apply with lock rising 100 cycles after pll_reset falls -> pll_reset high for exactly 16 cycles; rsp err=0.
REQ-036 Apply with lock held low, LOCK_TIMEOUT=50 -> rsp err=1 after 16+50 cycles plus latency; then req_ready=1.
REQ-037 req_op=11 -> rsp err=1, rdata=00; with VERIFY, a model corrupting readback -> err=1.
REQ-038 rst_n pulsed low during LOCKWAIT -> no rsp_valid, pll_reset=1 while low, then IDLE with req_ready=1.
